// File: rtl/accum_scheduler_if.sv
// Request/ack bus between the switch/key front end and the shared accumulator scheduler.
interface accum_scheduler_if;
  logic        req0;
  logic [7:0]  op0;
  logic        req1;
  logic [7:0]  op1;
  logic        ack0;
  logic        ack1;
  logic        busy;
  logic [15:0] acc0;
  logic [15:0] acc1;
  logic        ovf0;
  logic        ovf1;

  modport master (
    output req0, op0, req1, op1,
    input  ack0, ack1, busy, acc0, acc1, ovf0, ovf1
  );

  modport slave (
    input  req0, op0, req1, op1,
    output ack0, ack1, busy, acc0, acc1, ovf0, ovf1
  );
endinterface

// File: rtl/accum_scheduler.sv
// Two 16-bit accumulators sharing one 8-bit ripple adder, round-robin arbitrated.
// Define ACCUM_SATURATE_EN to saturate at 16'hFFFF instead of wrapping.
module accum_scheduler #(
  parameter logic        LAST_INIT = 1'b1,
  parameter logic [15:0] ACC_INIT  = 16'h0000
) (
  input logic              clock,
  input logic              resetN,
  input logic              clr,
  accum_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  op_q, op_d;
  logic        c8_q, c8_d;
  logic [15:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic        ovf0_q, ovf0_d, ovf1_q, ovf1_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;

  logic        elig0, elig1, pick;
  logic [15:0] acc_sel, acc_new;
  logic        ovf_set;
  logic [7:0]  add_a, add_b, add_sum;
  logic [8:0]  carry;

  // Single shared adder: operand byte selected by stage, accumulator by grant.
  always_comb begin
    acc_sel  = gnt_q ? acc1_q : acc0_q;
    add_a    = (state_q == StHi) ? acc_sel[15:8] : acc_sel[7:0];
    add_b    = (state_q == StLo) ? op_q : 8'h00;
    carry    = '0;
    carry[0] = (state_q == StHi) ? c8_q : 1'b0;
    add_sum  = '0;
    for (int i = 0; i < 8; i++) begin
      add_sum[i]   = add_a[i] ^ add_b[i] ^ carry[i];
      carry[i + 1] = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    c8_d    = c8_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    ovf0_d  = ovf0_q;
    ovf1_d  = ovf1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    acc_new = acc_sel;
    ovf_set = 1'b0;
    elig0   = bus.req0 & ~ack0_q;
    elig1   = bus.req1 & ~ack1_q;
    pick    = (elig0 & elig1) ? ~last_q : elig1;

    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          gnt_d   = pick;
          last_d  = pick;
          op_d    = pick ? bus.op1 : bus.op0;
          state_d = StLo;
        end
      end
      StLo: begin
        acc_new = {acc_sel[15:8], add_sum};
        c8_d    = carry[8];
        state_d = StHi;
      end
      StHi: begin
`ifdef ACCUM_SATURATE_EN
        acc_new = carry[8] ? 16'hFFFF : {add_sum, acc_sel[7:0]};
`else
        acc_new = {add_sum, acc_sel[7:0]};
`endif
        ovf_set = carry[8];
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Only the granted accumulator is ever written.
    if (state_q != StIdle) begin
      if (gnt_q) begin
        acc1_d = acc_new;
        ovf1_d = ovf1_q | ovf_set;
      end else begin
        acc0_d = acc_new;
        ovf0_d = ovf0_q | ovf_set;
      end
    end

    // Clear aborts any operation in flight but keeps the round-robin pointer.
    if (clr) begin
      state_d = StIdle;
      last_d  = last_q;
      acc0_d  = ACC_INIT;
      acc1_d  = ACC_INIT;
      ovf0_d  = 1'b0;
      ovf1_d  = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= LAST_INIT;
      op_q    <= '0;
      c8_q    <= 1'b0;
      acc0_q  <= ACC_INIT;
      acc1_q  <= ACC_INIT;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      c8_q    <= c8_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.acc0 = acc0_q;
  assign bus.acc1 = acc1_q;
  assign bus.ovf0 = ovf0_q;
  assign bus.ovf1 = ovf1_q;

endmodule

// File: tb/tb_accum_scheduler.sv
// Self-checking bench for accum_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_accum_scheduler;

  logic clock = 1'b0;
  logic resetN;
  logic clr;

  always #5 clock = ~clock;

  accum_scheduler_if bus ();

  accum_scheduler #(
    .LAST_INIT (1'b1),
    .ACC_INIT  (16'h0000)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .clr    (clr),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an add takes three edges (grant, low, high) and the
  // full 16-bit sum lands at the end; ack follows for one cycle.
  int unsigned m_acc [2] = '{0, 0};
  bit          m_ovf [2] = '{0, 0};
  bit          m_ack [2] = '{0, 0};
  int          m_phase   = 0;
  int          m_gnt     = 0;
  int unsigned m_op      = 0;
  bit          m_last    = 1'b1;

  task automatic model_step();
    bit e0, e1;
    int unsigned sum;
    if (!resetN) begin
      m_acc   = '{0, 0};
      m_ovf   = '{0, 0};
      m_ack   = '{0, 0};
      m_phase = 0;
      m_last  = 1'b1;
    end else if (clr) begin
      m_acc   = '{0, 0};
      m_ovf   = '{0, 0};
      m_ack   = '{0, 0};
      m_phase = 0;
    end else begin
      e0 = bus.req0 && !m_ack[0];
      e1 = bus.req1 && !m_ack[1];
      m_ack = '{0, 0};
      case (m_phase)
        0: if (e0 || e1) begin
          m_gnt   = (e0 && e1) ? int'(!m_last) : int'(e1);
          m_last  = bit'(m_gnt);
          m_op    = (m_gnt == 1) ? int'(bus.op1) : int'(bus.op0);
          m_phase = 1;
        end
        1: m_phase = 2;
        default: begin
          sum = m_acc[m_gnt] + m_op;
          if (sum > 32'hFFFF) begin
            m_ovf[m_gnt] = 1'b1;
`ifdef ACCUM_SATURATE_EN
            sum = 32'hFFFF;
`else
            sum = sum - 32'h10000;
`endif
          end
          m_acc[m_gnt] = sum;
          m_ack[m_gnt] = 1'b1;
          m_phase      = 0;
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetN);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check("ack0", bus.ack0, m_ack[0]);
      check("ack1", bus.ack1, m_ack[1]);
      check("busy", bus.busy, m_phase != 0);
      check("ovf0", bus.ovf0, m_ovf[0]);
      check("ovf1", bus.ovf1, m_ovf[1]);
      if (m_phase == 0 || m_gnt != 0) check("acc0", bus.acc0, m_acc[0]);
      if (m_phase == 0 || m_gnt != 1) check("acc1", bus.acc1, m_acc[1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic ack_of(input int i);
    return (i == 0) ? bus.ack0 : bus.ack1;
  endfunction

  task automatic set_req(input int i, input logic r, input logic [7:0] op);
    if (i == 0) begin
      bus.req0 = r;
      bus.op0  = op;
    end else begin
      bus.req1 = r;
      bus.op1  = op;
    end
  endtask

  // Raise a request, wait (bounded) for its ack, drop it in the ack cycle.
  task automatic do_add(input int i, input logic [7:0] op, output int lat);
    @(negedge clock);
    set_req(i, 1'b1, op);
    lat = 0;
    repeat (12) begin
      @(negedge clock);
      lat++;
      if (ack_of(i)) break;
    end
    check($sformatf("ack%0d_seen", i), ack_of(i), 1'b1);
    set_req(i, 1'b0, op);
  endtask

  function automatic logic [7:0] rnd_op();
    return ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  int          lat;
  int          order [$];
  logic [15:0] exp_wrap;

  initial begin
    resetN   = 1'b0;
    clr      = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0  = 8'h00;
    bus.op1  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_acc0", bus.acc0, 16'h0000);
    check("rst_acc1", bus.acc1, 16'h0000);
    resetN = 1'b1;

    // Simple add with latency.
    do_add(0, 8'h05, lat);
    check("t2_latency", lat, 3);
    check("t2_acc0", bus.acc0, 16'h0005);
    check("t2_acc1", bus.acc1, 16'h0000);
    @(negedge clock);
    check("t2_ack_pulse", bus.ack0, 1'b0);

    // Low-byte carry into the high byte.
    do_add(0, 8'hFA, lat);
    check("t3_acc0_ff", bus.acc0, 16'h00FF);
    do_add(0, 8'h01, lat);
    check("t3_acc0", bus.acc0, 16'h0100);
    check("t3_ovf0", bus.ovf0, 1'b0);

    // Reset during the low stage aborts; held request is re-granted after release.
    @(negedge clock);
    bus.req0 = 1'b1;
    bus.op0  = 8'h33;
    @(negedge clock);
    check("t1_busy_lo", bus.busy, 1'b1);
    #2 resetN = 1'b0;
    #1;
    check("t1_rst_busy", bus.busy, 1'b0);
    check("t1_rst_acc0", bus.acc0, 16'h0000);
    check("t1_rst_ack0", bus.ack0, 1'b0);
    @(negedge clock);
    check("t1_no_ack0", bus.ack0, 1'b0);
    resetN = 1'b1;
    repeat (12) begin
      @(negedge clock);
      if (bus.ack0) break;
    end
    check("t1_regrant_ack0", bus.ack0, 1'b1);
    check("t1_acc0", bus.acc0, 16'h0033);
    bus.req0 = 1'b0;

    // Both requesters held: strict alternation starting with requester 0.
    @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    resetN   = 1'b1;
    bus.req0 = 1'b1;
    bus.op0  = 8'h01;
    bus.req1 = 1'b1;
    bus.op1  = 8'h02;
    repeat (30) begin
      @(negedge clock);
      if (bus.ack0) order.push_back(0);
      if (bus.ack1) order.push_back(1);
      if (order.size() >= 4) break;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("t4_ack_count", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++)
      check($sformatf("t4_order%0d", k), order[k], k % 2);
    check("t4_acc0", bus.acc0, 16'h0002);
    check("t4_acc1", bus.acc1, 16'h0004);

    // Overflow on requester 1.
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    check("clr_acc0", bus.acc0, 16'h0000);
    for (int k = 0; k < 256; k++) do_add(1, 8'hFF, lat);
    do_add(1, 8'hFE, lat);
    check("t5_acc1_fffe", bus.acc1, 16'hFFFE);
    check("t5_ovf1_pre", bus.ovf1, 1'b0);
    do_add(1, 8'h03, lat);
`ifdef ACCUM_SATURATE_EN
    exp_wrap = 16'hFFFF;
`else
    exp_wrap = 16'h0001;
`endif
    check("t5_acc1", bus.acc1, exp_wrap);
    check("t5_ovf1", bus.ovf1, 1'b1);

    // Clear during the high stage of a requester-1 add.
    do_add(0, 8'h20, lat);
    check("t6_acc0_pre", bus.acc0, 16'h0020);
    @(negedge clock);
    bus.req1 = 1'b1;
    bus.op1  = 8'h05;
    @(negedge clock);
    @(negedge clock);
    check("t6_busy_hi", bus.busy, 1'b1);
    clr      = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clock);
    clr = 1'b0;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_ack1", bus.ack1, 1'b0);
    check("t6_acc0", bus.acc0, 16'h0000);
    check("t6_acc1", bus.acc1, 16'h0000);
    check("t6_ovf1", bus.ovf1, 1'b0);
    @(negedge clock);
    check("t6_ack1_late", bus.ack1, 1'b0);

    // Randomized traffic; operands are scrambled after grant to prove latching.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      clr = ($urandom_range(0, 2499) == 0);
      if (bus.req0 && m_ack[0]) bus.req0 = 1'b0;
      else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1;
        bus.op0  = rnd_op();
      end else if (bus.req0 && m_phase != 0 && m_gnt == 0) bus.op0 = 8'($urandom);
      if (bus.req1 && m_ack[1]) bus.req1 = 1'b0;
      else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1;
        bus.op1  = rnd_op();
      end else if (bus.req1 && m_phase != 0 && m_gnt == 1) bus.op1 = 8'($urandom);
    end
    @(negedge clock);
    clr      = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (6) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
